serdes_rx_framer: RTL and testbench
===================================

Name: serdes_rx_framer

Overview:
Downstream consumer of the SERDES serial output. It takes the recovered serial bit stream, bit-aligns to a sync byte and parses length-prefixed frames. It delivers payload bytes with valid/start strobes and checks a CRC-8 trailer. It also keeps good/bad frame counters for debug readout.

Parameters:
SYNC_BYTE, 8'h7E, frame delimiter searched bit-by-bit while hunting
MAX_LEN, 64, largest legal payload length in bytes (1..255)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
bit_en  input  1  qualifies ser_in; one bit consumed per cycle with bit_en=1
ser_in  input  1  serial data bit, MSB of each byte first
data_out  output  8  payload byte, held until next payload byte
data_valid  output  1  one-cycle strobe, data_out carries a new payload byte
sof  output  1  high with data_valid on first payload byte of a frame
locked  output  1  high while not in HUNT (frame in progress)
frame_done  output  1  one-cycle strobe after CRC byte received
crc_ok  output  1  valid with frame_done: received CRC matches computed CRC; held until next frame_done
len_err  output  1  one-cycle strobe, length byte 0 or greater than MAX_LEN
good_cnt  output  8  frames with crc_ok=1, wraps 255->0
bad_cnt  output  8  frames with CRC mismatch plus length errors, wraps 255->0

Behaviour:
- Clocking and reset: single clock domain. With rst=1 at a clock edge, all outputs are 0, state is HUNT, and the shift register, bit counter, byte counter and CRC are cleared. rst overrides bit_en. Reset mid-frame discards the frame with no strobes and no counter update.
- Cycles with bit_en=0 change no state. Strobes stay 0 in those cycles.
- Shift register: sr <= {sr[6:0], ser_in} on each bit_en. A byte completes on the 8th bit_en after entering a byte-collecting state.
- HUNT:
  - Compare {sr[6:0], ser_in} against SYNC_BYTE on every bit_en. Matching is bit-aligned; no byte boundary is assumed.
  - On a match, go to LEN, clear the bit counter and set the CRC to 8'h00.
- LEN: collect 8 bits into the length register, updating the CRC per bit.
  - Length 0 or greater than MAX_LEN: pulse len_err, increment bad_cnt, return to HUNT with sr cleared.
  - Otherwise go to PAYLOAD with byte counter = length.
- PAYLOAD:
  - Per bit, CRC update: crc <= {crc[6:0],1'b0} ^ ((crc[7]^ser_in) ? 8'h07 : 8'h00).
  - Each completed byte drives data_out and data_valid on the next clock edge, i.e. registered, one cycle after the 8th bit's bit_en. sof is set on the first byte only.
  - Decrement the byte counter per byte; at 0 go to CRC.
  - SYNC_BYTE values inside LEN, PAYLOAD or CRC are ordinary data. There is no resync mid-frame.
- CRC: collect 8 bits without updating the CRC.
  - On the next edge pulse frame_done, and set crc_ok = (received == computed).
  - Increment good_cnt or bad_cnt accordingly, then go to HUNT with sr cleared, so a new sync needs 8 fresh bits.
- locked=1 in LEN, PAYLOAD and CRC; 0 in HUNT. It deasserts the cycle frame_done or len_err pulses.
- Back-to-back frames with continuous bit_en: the first sync bit may arrive on the bit immediately after the CRC byte's last bit.
- CRC-8: poly 0x07, init 0x00, no reflection, no final XOR. Coverage is the length byte plus the payload bytes.

Test Plan:
- Basic frame: bit_en=1 continuously; stream 7E 01 AB 4D MSB-first -> one data_valid with data_out=AB and sof=1; frame_done=1 with crc_ok=1; good_cnt=1, bad_cnt=0.
- Bad CRC: stream 7E 01 AB 4C -> data_out=AB delivered; frame_done with crc_ok=0; bad_cnt=1, good_cnt unchanged.
- Bit alignment with gaps: 3 junk bits 1,0,1 then 7E 01 AB 4D, with bit_en toggling 1/0 every cycle -> same result as the basic frame; no strobes during bit_en=0 cycles.
- Length error: 7E 00 then 7E 41 (65 > MAX_LEN=64) -> two len_err pulses; bad_cnt=2; locked returns to 0 after each; no data_valid.
- Sync inside payload: 7E 02 7E 7E then the correct CRC -> two data_valid with data_out=7E, sof only on the first; crc_ok=1; no restart.
- Mid-frame reset: assert rst for 1 cycle after 7E 01 -> all outputs 0, counters 0; a following 7E 01 AB 4D is parsed correctly.

Source files
------------

// File: rtl/serdes_rx_framer.sv
// Receive-side framer for the recovered serial stream.
// Hunts bit-by-bit for the sync byte, then parses a length byte, that many
// payload bytes and a CRC-8 trailer. The CRC covers the length and payload
// bytes. Payload bytes come out with a valid strobe and a start-of-frame
// flag. Good and bad frame counters are kept for debug readout.
module serdes_rx_framer #(
    parameter logic [7:0] SYNC_BYTE = 8'h7E,
    parameter int unsigned MAX_LEN  = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_en,
    input  logic       ser_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       sof,
    output logic       locked,
    output logic       frame_done,
    output logic       crc_ok,
    output logic       len_err,
    output logic [7:0] good_cnt,
    output logic [7:0] bad_cnt
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_LEN     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CRC     = 2'd3
    } state_t;

    // One step of the MSB-first CRC-8 (poly 0x07, no reflection) for one bit.
    function automatic logic [7:0] crc8_bit(input logic [7:0] crc, input logic din);
        return {crc[6:0], 1'b0} ^ (((crc[7] ^ din) == 1'b1) ? 8'h07 : 8'h00);
    endfunction

    state_t     state_q, state_d;
    logic [7:0] sr_q, sr_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] byte_cnt_q, byte_cnt_d;
    logic [7:0] crc_q, crc_d;
    logic       first_q, first_d;
    logic [7:0] data_out_q, data_out_d;
    logic       data_valid_q, data_valid_d;
    logic       sof_q, sof_d;
    logic       locked_q, locked_d;
    logic       frame_done_q, frame_done_d;
    logic       crc_ok_q, crc_ok_d;
    logic       len_err_q, len_err_d;
    logic [7:0] good_cnt_q, good_cnt_d;
    logic [7:0] bad_cnt_q, bad_cnt_d;

    logic [7:0] shift_s;
    logic       byte_done_s;

    assign shift_s     = {sr_q[6:0], ser_in};
    assign byte_done_s = (bit_cnt_q == 3'd7);

    // Next-state and output computation; nothing moves unless bit_en is high.
    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        crc_d        = crc_q;
        first_d      = first_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        sof_d        = 1'b0;
        frame_done_d = 1'b0;
        crc_ok_d     = crc_ok_q;
        len_err_d    = 1'b0;
        good_cnt_d   = good_cnt_q;
        bad_cnt_d    = bad_cnt_q;

        if (bit_en) begin
            sr_d = shift_s;
            case (state_q)
                ST_HUNT: begin
                    // Sliding-window match: any bit position may start a frame.
                    if (shift_s == SYNC_BYTE) begin
                        state_d   = ST_LEN;
                        bit_cnt_d = 3'd0;
                        crc_d     = 8'h00;
                    end else begin
                        state_d = ST_HUNT;
                    end
                end
                ST_LEN: begin
                    crc_d     = crc8_bit(crc_q, ser_in);
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (byte_done_s) begin
                        if ((shift_s == 8'd0) || (shift_s > MAX_LEN_B)) begin
                            len_err_d = 1'b1;
                            bad_cnt_d = bad_cnt_q + 8'd1;
                            state_d   = ST_HUNT;
                            sr_d      = 8'h00;
                        end else begin
                            byte_cnt_d = shift_s;
                            first_d    = 1'b1;
                            state_d    = ST_PAYLOAD;
                        end
                    end else begin
                        state_d = ST_LEN;
                    end
                end
                ST_PAYLOAD: begin
                    crc_d     = crc8_bit(crc_q, ser_in);
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (byte_done_s) begin
                        data_out_d   = shift_s;
                        data_valid_d = 1'b1;
                        sof_d        = first_q;
                        first_d      = 1'b0;
                        byte_cnt_d   = byte_cnt_q - 8'd1;
                        if (byte_cnt_q == 8'd1) begin
                            state_d = ST_CRC;
                        end else begin
                            state_d = ST_PAYLOAD;
                        end
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
                ST_CRC: begin
                    // The trailer itself is not folded into the CRC.
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (byte_done_s) begin
                        frame_done_d = 1'b1;
                        if (shift_s == crc_q) begin
                            crc_ok_d   = 1'b1;
                            good_cnt_d = good_cnt_q + 8'd1;
                        end else begin
                            crc_ok_d  = 1'b0;
                            bad_cnt_d = bad_cnt_q + 8'd1;
                        end
                        // Clear the window so the next sync is built from fresh bits.
                        state_d = ST_HUNT;
                        sr_d    = 8'h00;
                    end else begin
                        state_d = ST_CRC;
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                    sr_d    = 8'h00;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        // Registered from the next state so locked drops with frame_done/len_err.
        locked_d = (state_d != ST_HUNT);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_HUNT;
            sr_q         <= 8'h00;
            bit_cnt_q    <= 3'd0;
            byte_cnt_q   <= 8'd0;
            crc_q        <= 8'h00;
            first_q      <= 1'b0;
            data_out_q   <= 8'h00;
            data_valid_q <= 1'b0;
            sof_q        <= 1'b0;
            locked_q     <= 1'b0;
            frame_done_q <= 1'b0;
            crc_ok_q     <= 1'b0;
            len_err_q    <= 1'b0;
            good_cnt_q   <= 8'd0;
            bad_cnt_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            crc_q        <= crc_d;
            first_q      <= first_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            sof_q        <= sof_d;
            locked_q     <= locked_d;
            frame_done_q <= frame_done_d;
            crc_ok_q     <= crc_ok_d;
            len_err_q    <= len_err_d;
            good_cnt_q   <= good_cnt_d;
            bad_cnt_q    <= bad_cnt_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign sof        = sof_q;
    assign locked     = locked_q;
    assign frame_done = frame_done_q;
    assign crc_ok     = crc_ok_q;
    assign len_err    = len_err_q;
    assign good_cnt   = good_cnt_q;
    assign bad_cnt    = bad_cnt_q;

endmodule

// File: tb/tb_serdes_rx_framer.sv
// Scoreboard bench for serdes_rx_framer: each scenario pushes the strobes it
// expects, a negedge monitor pops and compares them as the DUT produces them.
module tb_serdes_rx_framer;

    logic       clk;
    logic       rst;
    logic       bit_en;
    logic       ser_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       sof;
    logic       locked;
    logic       frame_done;
    logic       crc_ok;
    logic       len_err;
    logic [7:0] good_cnt;
    logic [7:0] bad_cnt;

    serdes_rx_framer #(.SYNC_BYTE(8'h7E), .MAX_LEN(64)) dut (
        .clk(clk), .rst(rst), .bit_en(bit_en), .ser_in(ser_in),
        .data_out(data_out), .data_valid(data_valid), .sof(sof),
        .locked(locked), .frame_done(frame_done), .crc_ok(crc_ok),
        .len_err(len_err), .good_cnt(good_cnt), .bad_cnt(bad_cnt)
    );

    // kind: 0 = payload byte, 1 = frame_done, 2 = len_err
    typedef struct {
        int         kind;
        logic [7:0] val;
        logic       sof;
    } exp_t;

    exp_t       sb[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_good = 8'd0;
    logic [7:0] exp_bad  = 8'd0;
    logic       en_last  = 1'b0;
    exp_t       cur;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Remember whether the most recent edge consumed a bit.
    always @(posedge clk) en_last <= bit_en;

    // Reference CRC-8 (poly 0x07), byte-at-a-time form.
    function automatic logic [7:0] crc8_ref(input logic [7:0] bytes[$]);
        logic [7:0] c;
        c = 8'h00;
        foreach (bytes[i]) begin
            c = c ^ bytes[i];
            for (int k = 0; k < 8; k++) begin
                if (c[7]) c = {c[6:0], 1'b0} ^ 8'h07;
                else      c = {c[6:0], 1'b0};
            end
        end
        return c;
    endfunction

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!rst) begin
            if (!en_last && (data_valid || frame_done || len_err)) begin
                n_tests++; n_fail++;
                $display("FAIL strobe_gap: dv=%b fd=%b le=%b after idle edge, want 0", data_valid, frame_done, len_err);
            end
            if (sof && !data_valid) begin
                n_tests++; n_fail++;
                $display("FAIL sof_alone: sof=1 with data_valid=0");
            end
            if (data_valid || frame_done || len_err) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: dv=%b fd=%b le=%b with empty scoreboard", data_valid, frame_done, len_err);
                end else begin
                    cur = sb.pop_front();
                    if (data_valid) begin
                        if (cur.kind != 0 || data_out !== cur.val || sof !== cur.sof) begin
                            n_fail++;
                            $display("FAIL sb_data: got data=%h sof=%b, want kind=%0d val=%h sof=%b",
                                     data_out, sof, cur.kind, cur.val, cur.sof);
                        end
                    end else if (frame_done) begin
                        if (cur.kind != 1 || crc_ok !== cur.val[0] || locked !== 1'b0) begin
                            n_fail++;
                            $display("FAIL sb_done: got crc_ok=%b locked=%b, want kind=%0d crc_ok=%b locked=0",
                                     crc_ok, locked, cur.kind, cur.val[0]);
                        end
                    end else begin
                        if (cur.kind != 2 || locked !== 1'b0) begin
                            n_fail++;
                            $display("FAIL sb_lenerr: got locked=%b, want kind=%0d locked=0", locked, cur.kind);
                        end
                    end
                end
            end
        end
    end

    task automatic push_exp(input int kind, input logic [7:0] val, input logic s);
        exp_t e;
        e.kind = kind; e.val = val; e.sof = s;
        sb.push_back(e);
    endtask

    task automatic send_bit(input logic b, input bit gap);
        @(negedge clk);
        bit_en = 1'b1;
        ser_in = b;
        if (gap) begin
            @(negedge clk);
            bit_en = 1'b0;
            ser_in = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        for (int i = 7; i >= 0; i--) send_bit(b[i], gap);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bit_en = 1'b0;
        ser_in = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; bit_en = 1'b1; ser_in = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({data_out, data_valid, sof, locked, frame_done, crc_ok, len_err} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, want 0",
                     {data_out, data_valid, sof, locked, frame_done, crc_ok, len_err});
        end
        n_tests++;
        if (good_cnt !== 8'd0 || bad_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_counters: got good=%0d bad=%0d, want 0 0", good_cnt, bad_cnt);
        end
        rst = 1'b0; bit_en = 1'b0; ser_in = 1'b0;
        exp_good = 8'd0; exp_bad = 8'd0;
    endtask

    task automatic test_basic;
        push_exp(0, 8'hAB, 1'b1);
        push_exp(1, 8'h01, 1'b0);
        exp_good++;
        send_byte(8'h7E, 0);
        send_byte(8'h01, 0);
        n_tests++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_locked: got %b, want 1", locked);
        end
        send_byte(8'hAB, 0);
        send_byte(8'h4D, 0);
        idle(4);
        n_tests++;
        if (sb.size() != 0 || good_cnt !== exp_good || bad_cnt !== exp_bad || locked !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_end: got pending=%0d good=%0d bad=%0d locked=%b, want 0 %0d %0d 0",
                     sb.size(), good_cnt, bad_cnt, locked, exp_good, exp_bad);
        end
        n_tests++;
        if (data_out !== 8'hAB || crc_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_hold: got data=%h crc_ok=%b, want AB 1", data_out, crc_ok);
        end
    endtask

    task automatic test_bad_crc;
        push_exp(0, 8'hAB, 1'b1);
        push_exp(1, 8'h00, 1'b0);
        exp_bad++;
        send_byte(8'h7E, 0);
        send_byte(8'h01, 0);
        send_byte(8'hAB, 0);
        send_byte(8'h4C, 0);
        idle(4);
        n_tests++;
        if (sb.size() != 0 || good_cnt !== exp_good || bad_cnt !== exp_bad || crc_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL badcrc_end: got pending=%0d good=%0d bad=%0d crc_ok=%b, want 0 %0d %0d 0",
                     sb.size(), good_cnt, bad_cnt, crc_ok, exp_good, exp_bad);
        end
    endtask

    task automatic test_gaps;
        push_exp(0, 8'hAB, 1'b1);
        push_exp(1, 8'h01, 1'b0);
        exp_good++;
        send_bit(1'b1, 1); send_bit(1'b0, 1); send_bit(1'b1, 1);
        send_byte(8'h7E, 1);
        send_byte(8'h01, 1);
        send_byte(8'hAB, 1);
        send_byte(8'h4D, 1);
        idle(4);
        n_tests++;
        if (sb.size() != 0 || good_cnt !== exp_good || bad_cnt !== exp_bad) begin
            n_fail++;
            $display("FAIL gaps_end: got pending=%0d good=%0d bad=%0d, want 0 %0d %0d",
                     sb.size(), good_cnt, bad_cnt, exp_good, exp_bad);
        end
    endtask

    task automatic test_len_err;
        push_exp(2, 8'h00, 1'b0);
        exp_bad++;
        send_byte(8'h7E, 0);
        send_byte(8'h00, 0);
        idle(2);
        n_tests++;
        if (locked !== 1'b0 || bad_cnt !== exp_bad) begin
            n_fail++;
            $display("FAIL lenerr_zero: got locked=%b bad=%0d, want 0 %0d", locked, bad_cnt, exp_bad);
        end
        push_exp(2, 8'h41, 1'b0);
        exp_bad++;
        send_byte(8'h7E, 0);
        send_byte(8'h41, 0);
        idle(2);
        n_tests++;
        if (sb.size() != 0 || locked !== 1'b0 || bad_cnt !== exp_bad || good_cnt !== exp_good) begin
            n_fail++;
            $display("FAIL lenerr_big: got pending=%0d locked=%b bad=%0d good=%0d, want 0 0 %0d %0d",
                     sb.size(), locked, bad_cnt, good_cnt, exp_bad, exp_good);
        end
    endtask

    task automatic test_max_len;
        logic [7:0] fr[$];
        fr = {8'd64};
        for (int i = 0; i < 64; i++) fr.push_back(8'(i * 7 + 3));
        for (int i = 0; i < 64; i++) push_exp(0, fr[i + 1], (i == 0));
        push_exp(1, 8'h01, 1'b0);
        exp_good++;
        send_byte(8'h7E, 0);
        foreach (fr[i]) send_byte(fr[i], 0);
        send_byte(crc8_ref(fr), 0);
        idle(4);
        n_tests++;
        if (sb.size() != 0 || good_cnt !== exp_good) begin
            n_fail++;
            $display("FAIL maxlen_end: got pending=%0d good=%0d, want 0 %0d", sb.size(), good_cnt, exp_good);
        end
    endtask

    task automatic test_sync_in_payload;
        logic [7:0] fr[$];
        fr = {8'h02, 8'h7E, 8'h7E};
        push_exp(0, 8'h7E, 1'b1);
        push_exp(0, 8'h7E, 1'b0);
        push_exp(1, 8'h01, 1'b0);
        exp_good++;
        send_byte(8'h7E, 0);
        foreach (fr[i]) send_byte(fr[i], 0);
        send_byte(crc8_ref(fr), 0);
        idle(4);
        n_tests++;
        if (sb.size() != 0 || good_cnt !== exp_good || bad_cnt !== exp_bad) begin
            n_fail++;
            $display("FAIL syncpay_end: got pending=%0d good=%0d bad=%0d, want 0 %0d %0d",
                     sb.size(), good_cnt, bad_cnt, exp_good, exp_bad);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] fr[$];
        fr = {8'h02, 8'h11, 8'h22};
        push_exp(0, 8'hAB, 1'b1);
        push_exp(1, 8'h01, 1'b0);
        push_exp(0, 8'h11, 1'b1);
        push_exp(0, 8'h22, 1'b0);
        push_exp(1, 8'h01, 1'b0);
        exp_good += 8'd2;
        send_byte(8'h7E, 0);
        send_byte(8'h01, 0);
        send_byte(8'hAB, 0);
        send_byte(8'h4D, 0);
        send_byte(8'h7E, 0);
        foreach (fr[i]) send_byte(fr[i], 0);
        send_byte(crc8_ref(fr), 0);
        idle(4);
        n_tests++;
        if (sb.size() != 0 || good_cnt !== exp_good || bad_cnt !== exp_bad) begin
            n_fail++;
            $display("FAIL b2b_end: got pending=%0d good=%0d bad=%0d, want 0 %0d %0d",
                     sb.size(), good_cnt, bad_cnt, exp_good, exp_bad);
        end
    endtask

    task automatic test_mid_reset;
        send_byte(8'h7E, 0);
        send_byte(8'h01, 0);
        @(negedge clk);
        rst = 1'b1; bit_en = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({data_out, data_valid, sof, locked, frame_done, crc_ok, len_err, good_cnt, bad_cnt} !== 30'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: data=%h dv=%b locked=%b crc_ok=%b good=%0d bad=%0d, want all 0",
                     data_out, data_valid, locked, crc_ok, good_cnt, bad_cnt);
        end
        rst = 1'b0;
        exp_good = 8'd0; exp_bad = 8'd0;
        push_exp(0, 8'hAB, 1'b1);
        push_exp(1, 8'h01, 1'b0);
        exp_good++;
        send_byte(8'h7E, 0);
        send_byte(8'h01, 0);
        send_byte(8'hAB, 0);
        send_byte(8'h4D, 0);
        idle(4);
        n_tests++;
        if (sb.size() != 0 || good_cnt !== exp_good || bad_cnt !== exp_bad || crc_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_end: got pending=%0d good=%0d bad=%0d crc_ok=%b, want 0 %0d %0d 1",
                     sb.size(), good_cnt, bad_cnt, crc_ok, exp_good, exp_bad);
        end
    endtask

    initial begin
        rst = 1'b1; bit_en = 1'b0; ser_in = 1'b0;
        test_reset;
        test_basic;
        test_bad_crc;
        test_gaps;
        test_len_err;
        test_sync_in_payload;
        test_max_len;
        test_back_to_back;
        test_mid_reset;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
